mem_lsu_adapter: RTL and testbench

- Byte-addressed load/store front end that sits directly upstream of the single-port synchronous SRAM (mem_sync_sp_syn) and drives its addr/wdata/byte-enable port.
- Accepts valid/ready requests of size byte, half or word. Generates byte enables and replicated write data, then aligns and sign/zero-extends read data.
- Returns one in-order response per request through a small response FIFO, so the SRAM's fixed 1-cycle read latency survives consumer backpressure.

---
 rtl/mem_lsu_pkg.sv | 63 ++++++
 rtl/mem_rsp_fifo.sv | 60 ++++++
 rtl/mem_lsu_adapter.sv | 111 +++++++++++
 tb/tb_mem_lsu_adapter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and helpers for the load/store adapter
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Request attributes carried across the one-cycle SRAM read latency
  typedef struct packed {
    logic       we;
    size_e      size;
    logic [1:0] off;
    logic       uns;
    logic       err;
  } inflight_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Illegal size or an address not aligned to the access size
  function automatic logic size_err(input size_e size, input logic [1:0] off);
    logic e;
    case (size)
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      SZ_ILL:  e = 1'b1;
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] byte_mask(input size_e size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Move the addressed lane down to bit 0, then sign- or zero-extend
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input size_e size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      SZ_HALF: r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      SZ_WORD: r = s;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - small synchronous FIFO with count and same-cycle push/pop
module mem_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_pop;

  assign full   = (count == CNT_W'(DEPTH));
  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a pop frees its slot in the same cycle as a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must never push into a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));

endmodule

// File: rtl/mem_lsu_adapter.sv
// rtl/mem_lsu_adapter.sv - byte-addressed load/store front end for a single-port SRAM
module mem_lsu_adapter
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RESP_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH+1:0]   i_req_addr,
  input  logic                    i_req_we,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [31:0]             i_req_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [31:0]             o_mem_wdata,
  output logic [3:0]              o_mem_wen,
  input  logic [31:0]             i_mem_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  size_e            req_size;
  logic             req_err;
  logic             accept;
  logic             ready_en;
  logic [CNT_W:0]   occupancy;
  logic             inflight_vld;
  inflight_t        inflight;
  rsp_t             push_rsp;
  rsp_t             head_rsp;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_count;

  assign req_size = size_e'(i_req_size);
  assign req_err  = size_err(req_size, i_req_addr[1:0]);

  // Queued plus in-flight responses bound how many requests may be outstanding
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_vld};
  assign o_req_ready = ready_en & (occupancy < (CNT_W + 1)'(RESP_DEPTH));
  assign accept      = i_req_valid & o_req_ready;

  // Holds ready low through reset and until the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // SRAM port drive: lane-replicated data, enables only for accepted legal stores
  always_comb begin
    o_mem_addr = i_req_addr[ADDR_WIDTH+1:2];
    o_mem_wen  = 4'b0000;
    case (req_size)
      SZ_BYTE: o_mem_wdata = {4{i_req_wdata[7:0]}};
      SZ_HALF: o_mem_wdata = {2{i_req_wdata[15:0]}};
      default: o_mem_wdata = i_req_wdata;
    endcase
    if (accept && i_req_we && !req_err) o_mem_wen = byte_mask(req_size, i_req_addr[1:0]);
  end

  // Remember what was asked for while the SRAM produces its read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_vld <= 1'b0;
      inflight     <= '0;
    end else begin
      inflight_vld <= accept;
      if (accept) begin
        inflight.we   <= i_req_we;
        inflight.size <= req_size;
        inflight.off  <= i_req_addr[1:0];
        inflight.uns  <= i_req_unsigned;
        inflight.err  <= req_err;
      end
    end
  end

  // Build the response from this cycle's SRAM data; stores and errors return zero
  always_comb begin
    push_rsp.err   = inflight.err;
    push_rsp.rdata = 32'h0;
    if (!inflight.we && !inflight.err)
      push_rsp.rdata = load_extend(i_mem_rdata, inflight.size, inflight.off, inflight.uns);
  end

  mem_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_vld),
    .push_data (push_rsp),
    .pop       (i_rsp_ready),
    .valid     (fifo_valid),
    .head      (head_rsp),
    .count     (fifo_count)
  );

  assign o_rsp_valid = fifo_valid;
  assign o_rsp_rdata = fifo_valid ? head_rsp.rdata : 32'h0;
  assign o_rsp_err   = fifo_valid & head_rsp.err;

endmodule

// File: tb/tb_mem_lsu_adapter.sv
// tb/tb_mem_lsu_adapter.sv - randomized self-checking bench for mem_lsu_adapter
module tb_mem_lsu_adapter;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  typedef struct packed {
    logic [AW+1:0] addr;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [3:0]    wen;
    logic [31:0]   wdata;
    logic [AW-1:0] maddr;
    int            cyc;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, o_req_ready, i_req_we, i_req_unsigned;
  logic [AW+1:0] i_req_addr;
  logic [1:0]    i_req_size;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [31:0]   o_rsp_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata, i_mem_rdata;
  logic [3:0]    o_mem_wen;

  mem_lsu_adapter #(.DEPTH(DEPTH), .RESP_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wen(o_mem_wen), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached single-port SRAM: byte-enabled write, registered read
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (o_mem_wen[j]) sram[o_mem_addr][8*j +: 8] <= o_mem_wdata[8*j +: 8];
    i_mem_rdata <= sram[o_mem_addr];
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] ref_mem [DEPTH*4];
  req_t req_q[$];
  exp_t exp_q[$];
  obs_t obs_q[$];
  acc_t acc_q[$];
  bit   rdy_q[$];
  int   stall;
  int   ncyc;

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // Byte-array memory model: what each request should answer, in program order
  function automatic exp_t model_apply(input req_t r);
    exp_t        e;
    int          n;
    logic [31:0] v;
    n = size_bytes(r.size);
    e = '0;
    if (r.size == 2'd3 || (int'(r.addr) % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (r.we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(r.addr) + i] = r.wdata[8*i +: 8];
      return e;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(r.addr) + i];
    if (!r.uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    e.rdata = v;
    return e;
  endfunction

  function automatic logic [3:0] exp_wen(input req_t r);
    logic [3:0] m;
    int         n;
    n = size_bytes(r.size);
    m = 4'b0000;
    if (r.we && r.size != 2'd3 && (int'(r.addr) % n) == 0)
      for (int i = 0; i < n; i++) m[(int'(r.addr) + i) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input req_t r);
    logic [31:0] d;
    int          n;
    n = size_bytes(r.size);
    for (int j = 0; j < 4; j++) d[8*j +: 8] = r.wdata[8*(j % n) +: 8];
    return d;
  endfunction

  function automatic void add_req(input int a, input bit we, input int sz, input bit uns, input logic [31:0] wd);
    req_t r;
    r.addr = (AW+2)'(a);
    r.we = we;
    r.size = 2'(sz);
    r.uns = uns;
    r.wdata = wd;
    req_q.push_back(r);
  endfunction

  task automatic build_expect();
    exp_q.delete();
    foreach (req_q[i]) exp_q.push_back(model_apply(req_q[i]));
  endtask

  // Offer req_q in order, drive response-ready, and record what the DUT does
  task automatic run(input int hold, input bit rand_rr, input int max_cyc, output bit done);
    int   idx;
    int   cyc;
    bit   rr;
    obs_t o;
    acc_t a;
    idx = 0;
    cyc = 0;
    done = 1'b0;
    stall = 0;
    obs_q.delete();
    acc_q.delete();
    rdy_q.delete();
    while (cyc < max_cyc) begin
      if (idx == req_q.size() && obs_q.size() >= req_q.size()) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      rr = (cyc < hold) ? 1'b0 : (rand_rr ? 1'($urandom_range(0, 1)) : 1'b1);
      i_rsp_ready = rr;
      if (idx < req_q.size()) begin
        i_req_valid    = 1'b1;
        i_req_addr     = req_q[idx].addr;
        i_req_we       = req_q[idx].we;
        i_req_size     = req_q[idx].size;
        i_req_unsigned = req_q[idx].uns;
        i_req_wdata    = req_q[idx].wdata;
      end else begin
        i_req_valid = 1'b0;
      end
      #1;
      rdy_q.push_back(o_req_ready);
      if (o_rsp_valid && rr) begin
        o.rdata = o_rsp_rdata;
        o.err = o_rsp_err;
        o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (i_req_valid && o_req_ready) begin
        a.wen = o_mem_wen;
        a.wdata = o_mem_wdata;
        a.maddr = o_mem_addr;
        a.cyc = cyc;
        acc_q.push_back(a);
        idx++;
      end else if (i_req_valid) begin
        stall++;
      end
      cyc++;
    end
    ncyc = cyc;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_addr = '0;
    i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    i_req_wdata = $urandom;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) sram[i] = 32'h0;
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0 || o_mem_wen !== 4'b0 ||
        o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got ready=%b rsp_valid=%b wen=%b rdata=%h err=%b, expected all zero",
               o_req_ready, o_rsp_valid, o_mem_wen, o_rsp_rdata, o_rsp_err);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    bit done;
    req_q.delete();
    add_req('h010, 0, 2, 0, 0);
    build_expect();
    run(0, 0, 20, done);
    n_tests++;
    if (!done || obs_q.size() != 1 || acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL latency completion: got %0d rsp %0d acc, expected 1 and 1", obs_q.size(), acc_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].cyc - acc_q[0].cyc !== 2) begin
        n_fail++;
        $display("FAIL latency cycles: got %0d, expected 2", obs_q[0].cyc - acc_q[0].cyc);
      end
      n_tests++;
      if (obs_q[0].rdata !== 32'h0 || obs_q[0].err !== 1'b0 || acc_q[0].wen !== 4'b0) begin
        n_fail++;
        $display("FAIL latency rsp: got %h/%b wen=%b, expected 00000000/0 wen=0000",
                 obs_q[0].rdata, obs_q[0].err, acc_q[0].wen);
      end
    end
  endtask

  task automatic test_subword();
    bit          done;
    logic [31:0] lit [8];
    lit = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h00000011, 32'hFFFF8044, 32'h00008044, 32'h0, 32'hBEEF0000};
    req_q.delete();
    add_req('h020, 1, 2, 0, 32'h11223344);
    add_req('h021, 1, 0, 0, 32'h00000080);
    add_req('h021, 0, 0, 0, 0);
    add_req('h023, 0, 0, 1, 0);
    add_req('h020, 0, 1, 0, 0);
    add_req('h020, 0, 1, 1, 0);
    add_req('h032, 1, 1, 0, 32'h0000BEEF);
    add_req('h030, 0, 2, 0, 0);
    build_expect();
    run(0, 0, 60, done);
    n_tests++;
    if (!done || obs_q.size() != 8 || acc_q.size() != 8) begin
      n_fail++;
      $display("FAIL subword completion: got %0d rsp %0d acc, expected 8 and 8", obs_q.size(), acc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (obs_q[i].rdata !== lit[i] || obs_q[i].err !== 1'b0) begin
          n_fail++;
          $display("FAIL subword rsp %0d: got %h/%b, expected %h/0", i, obs_q[i].rdata, obs_q[i].err, lit[i]);
        end
      end
      n_tests++;
      if (acc_q[1].wen !== 4'b0010 || acc_q[1].wdata !== 32'h80808080) begin
        n_fail++;
        $display("FAIL byte store drive: got wen=%b wdata=%h, expected 0010 80808080", acc_q[1].wen, acc_q[1].wdata);
      end
      n_tests++;
      if (acc_q[6].wen !== 4'b1100 || acc_q[6].wdata !== 32'hBEEFBEEF || acc_q[6].maddr !== 11'h00C) begin
        n_fail++;
        $display("FAIL half store drive: got wen=%b wdata=%h addr=%h, expected 1100 BEEFBEEF 00C",
                 acc_q[6].wen, acc_q[6].wdata, acc_q[6].maddr);
      end
      n_tests++;
      if (acc_q[0].wen !== 4'b1111 || acc_q[2].wen !== 4'b0 || acc_q[7].wen !== 4'b0) begin
        n_fail++;
        $display("FAIL word/load wen: got %b %b %b, expected 1111 0000 0000", acc_q[0].wen, acc_q[2].wen, acc_q[7].wen);
      end
    end
  endtask

  task automatic test_errors();
    bit          done;
    logic [31:0] lit [5];
    logic        lerr [5];
    lit  = '{32'h0, 32'h0, 32'h0, 32'hBEEF0000, 32'h0};
    lerr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    req_q.delete();
    add_req('h021, 0, 2, 0, 0);
    add_req('h033, 1, 1, 0, 32'h0000DEAD);
    add_req('h040, 1, 3, 0, 32'hFFFFFFFF);
    add_req('h030, 0, 2, 0, 0);
    add_req('h040, 0, 2, 0, 0);
    build_expect();
    run(0, 0, 60, done);
    n_tests++;
    if (!done || obs_q.size() != 5 || acc_q.size() != 5) begin
      n_fail++;
      $display("FAIL errors completion: got %0d rsp %0d acc, expected 5 and 5", obs_q.size(), acc_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (obs_q[i].rdata !== lit[i] || obs_q[i].err !== lerr[i] || acc_q[i].wen !== 4'b0) begin
          n_fail++;
          $display("FAIL errors rsp %0d: got %h/%b wen=%b, expected %h/%b wen=0000",
                   i, obs_q[i].rdata, obs_q[i].err, acc_q[i].wen, lit[i], lerr[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit done;
    int early;
    req_q.delete();
    add_req('h020, 0, 2, 0, 0);
    add_req('h030, 0, 2, 0, 0);
    add_req('h021, 0, 0, 0, 0);
    add_req('h020, 0, 1, 1, 0);
    add_req('h032, 0, 1, 0, 0);
    build_expect();
    run(8, 0, 60, done);
    early = 0;
    foreach (acc_q[i]) if (acc_q[i].cyc < 8) early++;
    n_tests++;
    if (early !== 3) begin
      n_fail++;
      $display("FAIL backpressure accepts: got %0d, expected 3", early);
    end
    n_tests++;
    if (rdy_q.size() < 8 || rdy_q[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure ready: got %b, expected 0", (rdy_q.size() < 8) ? 1'bx : rdy_q[7]);
    end
    n_tests++;
    if (!done || obs_q.size() != 5 || acc_q.size() != 5) begin
      n_fail++;
      $display("FAIL backpressure completion: got %0d rsp %0d acc, expected 5 and 5", obs_q.size(), acc_q.size());
    end else begin
      n_tests++;
      if (acc_q[3].cyc <= obs_q[0].cyc) begin
        n_fail++;
        $display("FAIL backpressure resume: got accept cycle %0d, expected after %0d", acc_q[3].cyc, obs_q[0].cyc);
      end
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err) begin
          n_fail++;
          $display("FAIL backpressure rsp %0d: got %h/%b, expected %h/%b",
                   i, obs_q[i].rdata, obs_q[i].err, exp_q[i].rdata, exp_q[i].err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    int s;
    int a;
    req_q.delete();
    for (int i = 0; i < 16; i++) begin
      s = $urandom_range(0, 2);
      a = ($urandom_range(0, 255) >> s) << s;
      add_req(a, 0, s, 1'($urandom_range(0, 1)), 0);
    end
    build_expect();
    run(0, 0, 60, done);
    n_tests++;
    if (!done || stall !== 0 || ncyc !== 18) begin
      n_fail++;
      $display("FAIL back_to_back rate: got done=%b stalls=%0d cycles=%0d, expected 1 0 18", done, stall, ncyc);
    end
    n_tests++;
    if (obs_q.size() != 16) begin
      n_fail++;
      $display("FAIL back_to_back count: got %0d, expected 16", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 16; i++) begin
      n_tests++;
      if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err) begin
        n_fail++;
        $display("FAIL back_to_back rsp %0d: got %h/%b, expected %h/%b",
                 i, obs_q[i].rdata, obs_q[i].err, exp_q[i].rdata, exp_q[i].err);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    req_q.delete();
    for (int i = 0; i < 60; i++)
      add_req('h100 + $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom);
    build_expect();
    run(0, 1, 2000, done);
    n_tests++;
    if (!done || obs_q.size() != 60 || acc_q.size() != 60) begin
      n_fail++;
      $display("FAIL random completion: got %0d rsp %0d acc, expected 60 and 60", obs_q.size(), acc_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 60; i++) begin
      n_tests++;
      if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err) begin
        n_fail++;
        $display("FAIL random rsp %0d: got %h/%b, expected %h/%b",
                 i, obs_q[i].rdata, obs_q[i].err, exp_q[i].rdata, exp_q[i].err);
      end
    end
    for (int i = 0; i < acc_q.size() && i < 60; i++) begin
      n_tests++;
      if (acc_q[i].wen !== exp_wen(req_q[i]) || acc_q[i].maddr !== req_q[i].addr[AW+1:2] ||
          (exp_wen(req_q[i]) != 4'b0 && acc_q[i].wdata !== exp_wdata(req_q[i]))) begin
        n_fail++;
        $display("FAIL random drive %0d: got wen=%b addr=%h wdata=%h, expected wen=%b addr=%h wdata=%h",
                 i, acc_q[i].wen, acc_q[i].maddr, acc_q[i].wdata,
                 exp_wen(req_q[i]), req_q[i].addr[AW+1:2], exp_wdata(req_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    bit stale;
    req_q.delete();
    add_req('h020, 0, 2, 0, 0);
    add_req('h030, 0, 2, 0, 0);
    add_req('h021, 0, 0, 0, 0);
    run(99, 0, 3, done);
    n_tests++;
    if (o_rsp_valid !== 1'b1 || acc_q.size() != 3) begin
      n_fail++;
      $display("FAIL mid-reset setup: got rsp_valid=%b accepts=%0d, expected 1 and 3", o_rsp_valid, acc_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0 || o_rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid-reset outputs: got rsp_valid=%b ready=%b rdata=%h, expected 0 0 00000000",
               o_rsp_valid, o_req_ready, o_rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (o_rsp_valid) stale = 1'b1;
    end
    i_rsp_ready = 1'b0;
    n_tests++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-reset stale response: got %b, expected 0", stale);
    end
    req_q.delete();
    add_req('h020, 0, 2, 0, 0);
    add_req('h030, 0, 2, 0, 0);
    build_expect();
    run(0, 0, 40, done);
    n_tests++;
    if (!done || obs_q.size() != 2 || obs_q[0].rdata !== 32'h11228044 || obs_q[1].rdata !== 32'hBEEF0000) begin
      n_fail++;
      $display("FAIL mid-reset readback: got %0d rsp %h %h, expected 2 rsp 11228044 BEEF0000", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].rdata : 32'hx, (obs_q.size() > 1) ? obs_q[1].rdata : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_subword();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
